// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one synchronous sprite ROM with tagged, fixed-latency returns
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 2
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_start,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_rd,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [15:0]             conflict_cnt
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0]                  ptr_q, ptr_d;
  logic [ADDR_W-1:0]              rom_addr_q, rom_addr_d;
  logic                           rom_rd_q, rom_rd_d;
  logic [ROM_LAT:0][N_REQ-1:0]    tag_q, tag_d;
  logic [N_REQ-1:0]               rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]              rd_data_q, rd_data_d;
  logic [15:0]                    cnt_q, cnt_d;
  logic                           found;
  int                             win;
  // first pending request at or after ptr (wrapping) wins; nothing is granted while in reset
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (Reset_n && !found && req[(int'(ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        win   = (int'(ptr_q) + k) % N_REQ;
      end
    end
    gnt[win] = found;
  end
  // issue the winner's read, age the one-hot tag alongside the ROM, and count contended cycles
  always_comb begin
    ptr_d      = frame_start ? '0 : found ? PW'((win + 1) % N_REQ) : ptr_q;
    rom_rd_d   = found;
    rom_addr_d = found ? req_addr[win*ADDR_W +: ADDR_W] : rom_addr_q;
    tag_d      = {tag_q[ROM_LAT-1:0], gnt};
    rd_valid_d = tag_q[ROM_LAT];
    rd_data_d  = |tag_q[ROM_LAT] ? rom_data : rd_data_q;
    cnt_d      = frame_start ? '0 : (|(req & (req - N_REQ'(1))) && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  // state registers; reset flushes the tag pipe so in-flight reads never return
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      rom_rd_q   <= 1'b0;
      tag_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      rom_rd_q   <= rom_rd_d;
      tag_q      <= tag_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      cnt_q      <= cnt_d;
    end
  end
  assign rom_addr     = rom_addr_q;
  assign rom_rd       = rom_rd_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed and random stimulus against a transaction-level model of the arbiter
module tb_sprite_rom_arbiter;
  localparam int N = 4, AW = 15, DW = 8;
  logic            Clk = 1'b0, Reset_n = 1'b0, frame_start = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    gnt, rd_valid;
  logic [AW-1:0]   rom_addr;
  logic            rom_rd;
  logic [DW-1:0]   rom_data = '0, rom_p1 = '0, rd_data;
  logic [15:0]     conflict_cnt;

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .conflict_cnt(conflict_cnt));

  always #10 Clk = ~Clk;

  // sprite ROM with two cycles of read latency; contents are the low address byte
  always @(posedge Clk) begin
    rom_p1   <= rom_rd ? rom_addr[7:0] : 8'h00;
    rom_data <= rom_p1;
  end

  typedef struct {int due; int idx; logic [7:0] data;} ret_t;
  ret_t        q[$];
  int          n_chk = 0, n_err = 0, cyc = 0, last_g = -1;
  int          m_ptr = 0, m_cnt = 0;
  logic        m_rom_rd = 1'b0;
  logic [14:0] m_rom_addr = '0;
  logic [3:0]  m_rd_valid = '0;
  logic [7:0]  m_rd_data = '0;
  logic [3:0]  on = '0;
  logic [14:0] ra [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    int best = -1, bd = 99;
    for (int i = 0; i < N; i++)
      if (r[i] && (i - p + N) % N < bd) begin
        bd   = (i - p + N) % N;
        best = i;
      end
    return best;
  endfunction

  function automatic logic [59:0] pk(input logic [14:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic cycle(input logic rst, input logic [3:0] r, input logic [59:0] a, input logic fs);
    int g, pc;
    Reset_n = rst; req = r; req_addr = a; frame_start = fs;
    #1;
    if (!rst) begin
      m_ptr = 0; m_cnt = 0; m_rom_rd = 0; m_rom_addr = '0; m_rd_valid = '0; m_rd_data = '0;
      q.delete();
    end
    g = rst ? pick(r, m_ptr) : -1;
    chk("gnt", {28'd0, gnt}, g < 0 ? 32'd0 : 32'd1 << g);
    chk("rom_rd", {31'd0, rom_rd}, {31'd0, m_rom_rd});
    chk("rom_addr", {17'd0, rom_addr}, {17'd0, m_rom_addr});
    chk("rd_valid", {28'd0, rd_valid}, {28'd0, m_rd_valid});
    chk("rd_data", {24'd0, rd_data}, {24'd0, m_rd_data});
    chk("conflict_cnt", {16'd0, conflict_cnt}, m_cnt);
    last_g = g;
    if (rst) begin
      pc = $countones(r);
      m_cnt = fs ? 0 : (pc >= 2 && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      m_ptr = fs ? 0 : g >= 0 ? (g + 1) % N : m_ptr;
      m_rom_rd = g >= 0;
      if (g >= 0) begin
        m_rom_addr = a[g*AW +: AW];
        q.push_back('{cyc + 4, g, a[g*AW +: 8]});
      end
      m_rd_valid = '0;
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        m_rd_valid = 4'd1 << q[0].idx;
        m_rd_data  = q[0].data;
        void'(q.pop_front());
      end
    end
    cyc++;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    @(negedge Clk);
    repeat (3) cycle(0, 4'b0000, '0, 0);
    cycle(1, 4'b0000, '0, 1);
    // single requester, address 0x1234 on requester 2
    cycle(1, 4'b0100, pk(15'h0, 15'h0, 15'h1234, 15'h0), 0);
    repeat (5) cycle(1, 4'b0000, '0, 0);
    // all four continuously requesting
    repeat (8) cycle(1, 4'b1111, pk(15'h0a1, 15'h1b2, 15'h2c3, 15'h3d4), 0);
    repeat (5) cycle(1, 4'b0000, '0, 0);
    // back-to-back from requester 1
    for (int i = 0; i < 3; i++) cycle(1, 4'b0010, pk(15'h0, 15'(10 + i), 15'h0, 15'h0), 0);
    repeat (5) cycle(1, 4'b0000, '0, 0);
    // pointer cleared by frame_start despite a simultaneous grant
    cycle(1, 4'b0100, pk(15'h0, 15'h0, 15'h55, 15'h0), 0);
    cycle(1, 4'b1000, pk(15'h0, 15'h0, 15'h0, 15'h66), 1);
    cycle(1, 4'b1001, pk(15'h77, 15'h0, 15'h0, 15'h88), 0);
    chk("fs_ptr_winner", {31'd0, rom_addr == 15'h77}, 32'd1);
    repeat (5) cycle(1, 4'b0000, '0, 0);
    // saturation of the contention counter
    repeat (70000) cycle(1, 4'b0011, pk(15'h101, 15'h202, 15'h0, 15'h0), 0);
    chk("cnt_saturated", {16'd0, conflict_cnt}, 32'h0000FFFF);
    cycle(1, 4'b0000, '0, 1);
    cycle(1, 4'b0000, '0, 0);
    // reset one cycle after a grant, released three cycles later
    cycle(1, 4'b0001, pk(15'h3ab, 15'h0, 15'h0, 15'h0), 0);
    repeat (3) cycle(0, 4'b0001, pk(15'h3cd, 15'h0, 15'h0, 15'h0), 0);
    cycle(1, 4'b0001, pk(15'h3cd, 15'h0, 15'h0, 15'h0), 0);
    repeat (5) cycle(1, 4'b0000, '0, 0);
    // random requesters that hold req until granted
    for (int i = 0; i < N; i++) ra[i] = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if (!on[i] && $urandom_range(0, 2) == 0) begin
          on[i] = 1'b1;
          ra[i] = 15'($urandom);
        end
      cycle($urandom_range(0, 300) != 0, on, pk(ra[0], ra[1], ra[2], ra[3]), $urandom_range(0, 40) == 0);
      if (last_g >= 0) begin
        if ($urandom_range(0, 1) == 0) on[last_g] = 1'b0;
        else ra[last_g] = 15'($urandom);
      end
    end
    repeat (6) cycle(1, 4'b0000, '0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous on-chip sprite ROM between up to N_REQ pixel-fetch requesters (background, fireboy, icegirl, elevator/gem layers).
- Each cycle, grants at most one request using round-robin priority and issues one ROM read per cycle.
- Returns the read data to the winning requester after a fixed pipeline latency.
- Sits between the per-object sprite controllers and the color mapper's shared ROM. Also keeps a per-frame contention counter for debug on the HEX displays.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 15, ROM word address width
DATA_W, 8, ROM data width (palette index)
ROM_LAT, 2, cycles from rom_rd asserted to rom_data valid (1..4)

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle pulse at start of each frame (synchronised VGA_VS edge)
req  in  N_REQ  request per requester, level, held until granted
req_addr  in  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
gnt  out  N_REQ  one-hot-or-zero grant, combinational in the request cycle
rom_addr  out  ADDR_W  registered ROM address
rom_rd  out  1  registered ROM read strobe
rom_data  in  DATA_W  ROM output, valid ROM_LAT cycles after rom_rd
rd_valid  out  N_REQ  one-hot-or-zero, registered; marks rd_data for requester i
rd_data  out  DATA_W  registered read data
conflict_cnt  out  16  cycles in the current frame with two or more requests pending

Behaviour:
- Reset (Reset_n low, async): gnt=0, rom_rd=0, rom_addr=0, rd_valid=0, rd_data=0, conflict_cnt=0, rr pointer=0. The tag pipeline is flushed, so in-flight reads are discarded and never produce rd_valid.
- Arbitration (combinational):
  - Scan req starting at index ptr, wrapping modulo N_REQ; the first set bit wins and gets gnt[i]=1.
  - No req set -> gnt=0.
  - gnt is never multi-hot.
- Pointer (registered):
  - On a grant to i, ptr <= (i+1) mod N_REQ.
  - No grant -> ptr holds.
  - frame_start -> ptr <= 0, overriding any grant update in the same cycle.
- Issue: in grant cycle t, at edge t+1: rom_addr <= req_addr[i], rom_rd <= 1, tag <= one-hot i. No grant -> rom_rd <= 0, rom_addr holds.
- Return:
  - The tag shift register delays the one-hot tag ROM_LAT cycles.
  - At the following edge, rd_data <= rom_data and rd_valid <= delayed tag.
  - rd_valid[i] rises exactly ROM_LAT+2 edges after grant cycle t (4 with defaults) and lasts 1 cycle per grant.
  - rd_data holds its value when rd_valid=0.
- Requester rule:
  - Keep req and address stable until the cycle gnt[i]=1.
  - The next cycle, a requester may drop req or present a new address with req still high (back-to-back).
  - A requester may have multiple reads in flight; returns arrive in grant order.
- Throughput: one grant and one ROM read per cycle whenever any req is set. With N requesters continuously requesting, each is served exactly once every N cycles.
- conflict_cnt:
  - +1 each cycle where popcount(req) >= 2; saturates at 16'hFFFF.
  - frame_start clears it to 0. Clear wins, so the frame_start cycle is not counted.
- frame_start does not disturb in-flight reads, rom_rd or rd_valid.
- Reset deasserted mid-frame: the block resumes with ptr=0, and requests are granted from the first edge after release.

Test Plan:
- Single requester: req=4'b0100, addr2=15'h1234, ROM returns addr[7:0] -> gnt=4'b0100 in cycle t; rom_addr=15'h1234, rom_rd=1 at t+1; rd_valid=4'b0100 and rd_data=8'h34 at t+4.
- All four requesting continuously from ptr=0 -> grant order 0,1,2,3,0,1. rd_valid follows the same order delayed by 4 cycles; conflict_cnt increments every cycle.
- Back-to-back from one requester: requester 1 issues addresses 10,11,12 on consecutive grants with no other requests -> three consecutive rd_valid=4'b0010 with data 10,11,12 in order.
- Pointer reset: grant to 2 (ptr=3), then frame_start pulses together with a grant to 3 -> ptr=0 next cycle. With req=4'b1001 next, requester 0 wins; conflict_cnt reads 0 the cycle after frame_start.
- Saturation: 70000 cycles of req=4'b0011 with no frame_start -> conflict_cnt stops at 16'hFFFF. A frame_start then yields 0.
- Reset mid-flight: assert Reset_n=0 one cycle after a grant, release 3 cycles later -> no rd_valid ever appears for that read. All outputs are 0 during reset; the first post-reset request is served normally with latency 4.
